// File: rtl/dmem_resp.sv
// Data-memory responder: captures a core data request and serves it from an internal RAM after WAIT cycles.
// Optional out-of-range address checking is enabled by defining DMEM_OOR_CHECK_EN.
module dmem_resp #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dAddr,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [15:0] dWdata,
    output logic [15:0] dRdata,
    output logic        dAck,
    output logic        dBusy,
    output logic        dErr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           addr_q, wdata_q, rdata_q;
    logic                  we_q;
    logic                  accept, enter_ack;
    logic [15:0]           txn_addr, txn_wdata;
    logic                  txn_we, txn_oor;
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0]           mem [2**DEPTH_LOG2];
    logic                  unused_capture;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        enter_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dReq) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_ACK;
                    enter_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With WAIT=0 the ACK edge is the accept edge, so the live inputs are the transaction.
    assign txn_addr  = (state_q == S_IDLE) ? dAddr  : addr_q;
    assign txn_wdata = (state_q == S_IDLE) ? dWdata : wdata_q;
    assign txn_we    = (state_q == S_IDLE) ? dWe    : we_q;
    assign idx       = txn_addr[DEPTH_LOG2-1:0];

`ifdef DMEM_OOR_CHECK_EN
    logic oor_q;
    logic in_oor;
    assign in_oor  = |(dAddr >> DEPTH_LOG2);
    assign txn_oor = (state_q == S_IDLE) ? in_oor : oor_q;
    assign dErr    = (state_q == S_ACK) && oor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       oor_q <= 1'b0;
        else if (accept) oor_q <= in_oor;
    end
`else
    assign txn_oor = 1'b0;
    assign dErr    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            we_q    <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= dAddr;
                wdata_q <= dWdata;
                we_q    <= dWe;
            end
            if (enter_ack && !txn_we && !txn_oor)
                rdata_q <= mem[idx];
        end
    end

    // RAM has no reset; reset still blocks a commit so a request coincident with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && enter_ack && txn_we && !txn_oor)
            mem[idx] <= txn_wdata;
    end

    assign unused_capture = ^{addr_q, wdata_q, we_q};

    assign dRdata = rdata_q;
    assign dAck   = (state_q == S_ACK);
    assign dBusy  = (state_q != S_IDLE);

endmodule
